// File: rtl/fifo_pkt_framer.sv
// fifo_pkt_framer: pops FWFT words {sop, eop, mod, data} from the read side of
// the async block FIFO and re-emits them as a valid/ready beat stream through a
// one-deep output register. Packets are checked for correct sop/eop framing
// and for a maximum length. Good packets and framing errors are counted.
module fifo_pkt_framer #(
    parameter int DWID      = 64,
    parameter int MWID      = 3,
    parameter int MAX_WORDS = 256,
    parameter int LWID      = 9,
    parameter int CNT_WID   = 32,
    parameter int DBG_WID   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fifo_nempty,
    output logic                   fifo_ren,
    input  logic [DWID+MWID+1:0]   fifo_rdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DWID-1:0]        out_data,
    output logic [MWID-1:0]        out_mod,
    output logic                   out_sop,
    output logic                   out_eop,
    output logic                   out_err,
    output logic [CNT_WID-1:0]     pkt_cnt,
    output logic [CNT_WID-1:0]     err_cnt,
    output logic [DBG_WID-1:0]     dbg
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BODY = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    localparam logic [LWID-1:0] MAX_L    = LWID'(MAX_WORDS);
    localparam bit              ONE_WORD = (MAX_WORDS == 1);

    // Fields of the FIFO head word.
    logic              w_sop;
    logic              w_eop;
    logic [MWID-1:0]   w_mod;
    logic [DWID-1:0]   w_data;

    assign w_sop  = fifo_rdata[DWID+MWID+1];
    assign w_eop  = fifo_rdata[DWID+MWID];
    assign w_mod  = fifo_rdata[DWID+MWID-1:DWID];
    assign w_data = fifo_rdata[DWID-1:0];

    // Registered state and outputs.
    state_t            r_state;
    logic [LWID-1:0]   r_wcnt;
    logic              r_valid;
    logic [DWID-1:0]   r_data;
    logic [MWID-1:0]   r_mod;
    logic              r_sop;
    logic              r_eop;
    logic              r_err;
    logic [CNT_WID-1:0] r_pkt_cnt;
    logic [CNT_WID-1:0] r_err_cnt;

    // Combinational decisions for this cycle.
    state_t            w_nxt_state;
    logic [LWID-1:0]   w_nxt_wcnt;
    logic [LWID-1:0]   w_wcnt_inc;
    logic              w_ld_ok;
    logic              w_ren;
    logic              w_load;
    logic [DWID-1:0]   w_ld_data;
    logic [MWID-1:0]   w_ld_mod;
    logic              w_ld_sop;
    logic              w_ld_eop;
    logic              w_ld_err;
    logic              w_err_inc;

    assign w_ld_ok    = !r_valid || out_ready;
    assign w_wcnt_inc = r_wcnt + {{(LWID-1){1'b0}}, 1'b1};

    // Next-state, pop and load decisions for the framing FSM.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_wcnt  = r_wcnt;
        w_ren       = 1'b0;
        w_load      = 1'b0;
        w_ld_data   = w_data;
        w_ld_mod    = w_mod;
        w_ld_sop    = w_sop;
        w_ld_eop    = w_eop;
        w_ld_err    = 1'b0;
        w_err_inc   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!fifo_nempty) begin
                    w_nxt_state = ST_IDLE;
                end else if (w_sop) begin
                    if (w_ld_ok) begin
                        w_ren      = 1'b1;
                        w_load     = 1'b1;
                        w_nxt_wcnt = {{(LWID-1){1'b0}}, 1'b1};
                        if (w_eop) begin
                            w_nxt_state = ST_IDLE;
                        end else if (ONE_WORD) begin
                            // A one-beat limit truncates any multi-word packet at once.
                            w_ld_eop    = 1'b1;
                            w_ld_err    = 1'b1;
                            w_err_inc   = 1'b1;
                            w_nxt_state = ST_DROP;
                        end else begin
                            w_nxt_state = ST_BODY;
                        end
                    end else begin
                        w_nxt_state = ST_IDLE;
                    end
                end else begin
                    // Orphan word outside a packet: discard and count once.
                    w_ren     = 1'b1;
                    w_err_inc = 1'b1;
                    if (w_eop) begin
                        w_nxt_state = ST_IDLE;
                    end else begin
                        w_nxt_state = ST_DROP;
                    end
                end
            end
            ST_BODY: begin
                if (!fifo_nempty || !w_ld_ok) begin
                    w_nxt_state = ST_BODY;
                end else if (w_sop) begin
                    // Missing eop: close the packet with a terminator, keep the word.
                    w_load      = 1'b1;
                    w_ld_data   = {DWID{1'b0}};
                    w_ld_mod    = {MWID{1'b0}};
                    w_ld_sop    = 1'b0;
                    w_ld_eop    = 1'b1;
                    w_ld_err    = 1'b1;
                    w_err_inc   = 1'b1;
                    w_nxt_state = ST_IDLE;
                end else if (w_eop) begin
                    w_ren       = 1'b1;
                    w_load      = 1'b1;
                    w_nxt_state = ST_IDLE;
                end else begin
                    w_ren      = 1'b1;
                    w_load     = 1'b1;
                    w_nxt_wcnt = w_wcnt_inc;
                    if (w_wcnt_inc == MAX_L) begin
                        // Length limit reached: truncate here and drop the rest.
                        w_ld_eop    = 1'b1;
                        w_ld_err    = 1'b1;
                        w_err_inc   = 1'b1;
                        w_nxt_state = ST_DROP;
                    end else begin
                        w_nxt_state = ST_BODY;
                    end
                end
            end
            ST_DROP: begin
                if (!fifo_nempty) begin
                    w_nxt_state = ST_DROP;
                end else if (w_sop) begin
                    w_nxt_state = ST_IDLE;
                end else begin
                    w_ren = 1'b1;
                    if (w_eop) begin
                        w_nxt_state = ST_IDLE;
                    end else begin
                        w_nxt_state = ST_DROP;
                    end
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    // Pops are suppressed while reset is held so no word is lost during reset.
    assign fifo_ren = w_ren && fifo_nempty && !rst;

    // State register and word counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_wcnt  <= {LWID{1'b0}};
        end else begin
            r_state <= w_nxt_state;
            r_wcnt  <= w_nxt_wcnt;
        end
    end

    // One-deep output register with valid/ready handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= {DWID{1'b0}};
            r_mod   <= {MWID{1'b0}};
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_data  <= w_ld_data;
            r_mod   <= w_ld_mod;
            r_sop   <= w_ld_sop;
            r_eop   <= w_ld_eop;
            r_err   <= w_ld_err;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    // Good-packet and framing-error statistics, wrapping naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt_cnt <= {CNT_WID{1'b0}};
            r_err_cnt <= {CNT_WID{1'b0}};
        end else begin
            if (w_load && w_ld_eop && !w_ld_err) begin
                r_pkt_cnt <= r_pkt_cnt + {{(CNT_WID-1){1'b0}}, 1'b1};
            end else begin
                r_pkt_cnt <= r_pkt_cnt;
            end
            if (w_err_inc) begin
                r_err_cnt <= r_err_cnt + {{(CNT_WID-1){1'b0}}, 1'b1};
            end else begin
                r_err_cnt <= r_err_cnt;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_mod   = r_mod;
    assign out_sop   = r_sop;
    assign out_eop   = r_eop;
    assign out_err   = r_err;
    assign pkt_cnt   = r_pkt_cnt;
    assign err_cnt   = r_err_cnt;
    assign dbg       = {{(DBG_WID-6){1'b0}}, r_state, r_valid, out_ready, fifo_nempty, fifo_ren};

endmodule

// File: tb/tb_fifo_pkt_framer.sv
// Directed testbench for fifo_pkt_framer with a behavioural FWFT FIFO and an
// output beat log; expected values are hand-computed per step.
module tb_fifo_pkt_framer;

    localparam int DW = 64;
    localparam int MW = 3;
    localparam int W  = DW + MW + 2;

    logic          clk;
    logic          rst;
    logic          fifo_nempty;
    logic          fifo_ren;
    logic [W-1:0]  fifo_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [MW-1:0] out_mod;
    logic          out_sop;
    logic          out_eop;
    logic          out_err;
    logic [31:0]   pkt_cnt;
    logic [31:0]   err_cnt;
    logic [31:0]   dbg;

    fifo_pkt_framer #(
        .DWID(DW), .MWID(MW), .MAX_WORDS(4), .LWID(9), .CNT_WID(32), .DBG_WID(32)
    ) dut (
        .clk(clk), .rst(rst), .fifo_nempty(fifo_nempty), .fifo_ren(fifo_ren),
        .fifo_rdata(fifo_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_mod(out_mod), .out_sop(out_sop), .out_eop(out_eop),
        .out_err(out_err), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt), .dbg(dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural FWFT FIFO.
    logic [W-1:0] mem [0:511];
    int wp = 0;
    int rp = 0;
    assign fifo_nempty = (rp != wp);
    assign fifo_rdata  = (rp != wp) ? mem[rp] : '0;
    always @(posedge clk) if (fifo_ren) rp <= rp + 1;

    // Output beat log, sampled on the falling edge.
    logic [DW-1:0] b_data [0:511];
    logic [MW-1:0] b_mod  [0:511];
    logic          b_sop  [0:511];
    logic          b_eop  [0:511];
    logic          b_err  [0:511];
    int            b_cyc  [0:511];
    int nb  = 0;
    int cyc = 0;
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (out_valid && out_ready) begin
            b_data[nb] <= out_data;
            b_mod[nb]  <= out_mod;
            b_sop[nb]  <= out_sop;
            b_eop[nb]  <= out_eop;
            b_err[nb]  <= out_err;
            b_cyc[nb]  <= cyc;
            nb         <= nb + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic sop, input logic eop, input logic [MW-1:0] m, input logic [DW-1:0] d);
        mem[wp] = {sop, eop, m, d};
        wp = wp + 1;
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            if (rp == wp && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, {63'd0, ok}, 64'd1);
    endtask

    task automatic chk_beat(input string tag, input int idx, input logic [DW-1:0] d, input logic [MW-1:0] m,
                            input logic s, input logic e, input logic er);
        chk(tag, {b_data[idx]}, d);
        chk(tag, {58'd0, b_sop[idx], b_eop[idx], b_err[idx], b_mod[idx]}, {58'd0, s, e, er, m});
    endtask

    int n0;

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_flags", {59'd0, out_sop, out_eop, out_err, out_mod}, 64'd0);
        chk("rst_cnts", {pkt_cnt, err_cnt}, 64'd0);
        chk("rst_ren_state", {56'd0, dbg[7:0]}, 64'h04);
        rst = 1'b0;

        // Good 3-word packet with a one-cycle stall on beat 2.
        n0 = nb;
        push(1'b1, 1'b0, 3'd0, 64'hA1);
        push(1'b0, 1'b0, 3'd0, 64'hA2);
        push(1'b0, 1'b1, 3'd5, 64'hA3);
        @(posedge clk); #1;
        chk("t1_beat1", out_data, 64'hA1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        chk("t1_stall_data", out_data, 64'hA2);
        chk("t1_stall_vld", {62'd0, out_valid, out_sop}, 64'd2);
        out_ready = 1'b1;
        wait_idle("t1_idle");
        chk("t1_nbeats", nb - n0, 64'd3);
        chk_beat("t1_b0", n0,     64'hA1, 3'd0, 1'b1, 1'b0, 1'b0);
        chk_beat("t1_b1", n0 + 1, 64'hA2, 3'd0, 1'b0, 1'b0, 1'b0);
        chk_beat("t1_b2", n0 + 2, 64'hA3, 3'd5, 1'b0, 1'b1, 1'b0);
        chk("t1_cnts", {pkt_cnt, err_cnt}, {32'd1, 32'd0});

        // Orphan words, then a single-word packet.
        n0 = nb;
        push(1'b0, 1'b0, 3'd0, 64'hB1);
        push(1'b0, 1'b1, 3'd0, 64'hB2);
        push(1'b1, 1'b1, 3'd0, 64'hB3);
        wait_idle("t2_idle");
        chk("t2_nbeats", nb - n0, 64'd1);
        chk_beat("t2_b0", n0, 64'hB3, 3'd0, 1'b1, 1'b1, 1'b0);
        chk("t2_cnts", {pkt_cnt, err_cnt}, {32'd2, 32'd1});

        // Missing eop: terminator, then the held sop word as a new packet.
        n0 = nb;
        push(1'b1, 1'b0, 3'd0, 64'hC1);
        push(1'b0, 1'b0, 3'd0, 64'hC2);
        push(1'b1, 1'b1, 3'd3, 64'hC3);
        wait_idle("t3_idle");
        chk("t3_nbeats", nb - n0, 64'd4);
        chk_beat("t3_b0", n0,     64'hC1, 3'd0, 1'b1, 1'b0, 1'b0);
        chk_beat("t3_b1", n0 + 1, 64'hC2, 3'd0, 1'b0, 1'b0, 1'b0);
        chk_beat("t3_term", n0 + 2, 64'h0, 3'd0, 1'b0, 1'b1, 1'b1);
        chk_beat("t3_b3", n0 + 3, 64'hC3, 3'd3, 1'b1, 1'b1, 1'b0);
        chk("t3_cnts", {pkt_cnt, err_cnt}, {32'd3, 32'd2});

        // Overlength (limit 4): 6-word packet truncated, then a good 2-word packet.
        n0 = nb;
        push(1'b1, 1'b0, 3'd0, 64'hD0);
        for (int i = 1; i < 5; i++) push(1'b0, 1'b0, 3'd0, 64'hD0 + 64'(i));
        push(1'b0, 1'b1, 3'd0, 64'hD5);
        push(1'b1, 1'b0, 3'd0, 64'hE0);
        push(1'b0, 1'b1, 3'd2, 64'hE1);
        wait_idle("t4_idle");
        chk("t4_nbeats", nb - n0, 64'd6);
        chk_beat("t4_b0", n0,     64'hD0, 3'd0, 1'b1, 1'b0, 1'b0);
        chk_beat("t4_b2", n0 + 2, 64'hD2, 3'd0, 1'b0, 1'b0, 1'b0);
        chk_beat("t4_trunc", n0 + 3, 64'hD3, 3'd0, 1'b0, 1'b1, 1'b1);
        chk_beat("t4_g0", n0 + 4, 64'hE0, 3'd0, 1'b1, 1'b0, 1'b0);
        chk_beat("t4_g1", n0 + 5, 64'hE1, 3'd2, 1'b0, 1'b1, 1'b0);
        chk("t4_cnts", {pkt_cnt, err_cnt}, {32'd4, 32'd3});

        // Reset during beat 2 of a 4-word packet.
        push(1'b1, 1'b0, 3'd0, 64'hF0);
        push(1'b0, 1'b0, 3'd0, 64'hF1);
        push(1'b0, 1'b0, 3'd0, 64'hF2);
        push(1'b0, 1'b1, 3'd0, 64'hF3);
        @(posedge clk); #1;
        chk("t5_beat1", out_data, 64'hF0);
        @(posedge clk); #1;
        chk("t5_beat2", {out_data[62:0], out_sop}, {63'hF1, 1'b0});
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t5_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("t5_rst_data", out_data, 64'd0);
        chk("t5_rst_flags", {59'd0, out_sop, out_eop, out_err, out_mod}, 64'd0);
        chk("t5_rst_cnts", {pkt_cnt, err_cnt}, 64'd0);
        chk("t5_rst_ren", {63'd0, fifo_ren}, 64'd0);
        rst = 1'b0;
        n0 = nb;
        wait_idle("t5_idle");
        chk("t5_nbeats", nb - n0, 64'd0);
        chk("t5_cnts", {pkt_cnt, err_cnt}, {32'd0, 32'd1});

        // 100 back-to-back single-word packets.
        n0 = nb;
        for (int i = 0; i < 100; i++) push(1'b1, 1'b1, 3'(i), 64'h1000 + 64'(i));
        wait_idle("t6_idle");
        chk("t6_nbeats", nb - n0, 64'd100);
        chk("t6_consecutive", b_cyc[n0 + 99] - b_cyc[n0], 64'd99);
        for (int i = 0; i < 100; i += 11)
            chk_beat("t6_beat", n0 + i, 64'h1000 + 64'(i), 3'(i), 1'b1, 1'b1, 1'b0);
        chk("t6_cnts", {pkt_cnt, err_cnt}, {32'd100, 32'd1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
